// File: rtl/a2d_pkg.sv
// a2d_pkg: shared state types, round-robin index type and SPI divider constants for a2d_intf
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, CNV, GAP, READ} seq_state_t;
    typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_BACK_PORCH} spi_state_t;
    typedef logic [1:0] rr_idx_t;

    localparam logic [4:0] DIV_SMPL  = 5'b01111;
    localparam logic [4:0] DIV_SHFT  = 5'b11111;
    localparam logic [4:0] DIV_FRONT = 5'b10111;
    localparam logic [4:0] BITS      = 5'd16;

    function automatic logic [15:0] chan_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mnrch.sv
// spi_mnrch: 16-bit mode-3 SPI monarch, SCLK = clk/32 with a front porch before the first bit
module spi_mnrch
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    spi_state_t  state_q, state_d;
    logic [4:0]  div_q, div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shft_q, shft_d;
    logic        smpl_q, smpl_d;
    logic        ss_n_q, ss_n_d;
    logic        done_q, done_d;
    logic        shift_now;

    always_comb begin
        // the first SCLK fall after the front porch carries no sampled bit, so it must not shift
        shift_now = state_q == SPI_SHIFT && div_q == DIV_SHFT && bit_cnt_q != 5'd0;
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shft_d    = shft_q;
        smpl_d    = smpl_q;
        ss_n_d    = ss_n_q;
        done_d    = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                if (wrt) begin
                    state_d   = SPI_SHIFT;
                    div_d     = DIV_FRONT;
                    bit_cnt_d = 5'd0;
                    shft_d    = cmd;
                    ss_n_d    = 1'b0;
                end
            end
            SPI_SHIFT: begin
                div_d = div_q + 5'd1;
                if (div_q == DIV_SMPL) begin
                    smpl_d    = MISO;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (shift_now)
                    shft_d = {shft_q[14:0], smpl_q};
                if (shift_now && bit_cnt_q == BITS) begin
                    state_d = SPI_BACK_PORCH;
                    div_d   = div_q;
                end
            end
            SPI_BACK_PORCH: begin
                state_d = SPI_IDLE;
                ss_n_d  = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SPI_IDLE;
            div_q     <= DIV_SHFT;
            bit_cnt_q <= 5'd0;
            shft_q    <= 16'h0000;
            smpl_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shft_q    <= shft_d;
            smpl_q    <= smpl_d;
            ss_n_q    <= ss_n_d;
            done_q    <= done_d;
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[4];
    assign MOSI    = shft_q[15];
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin two-frame conversions over an 8-channel SPI A2D into four holding registers
module a2d_intf
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt
);

    seq_state_t  state_q, state_d;
    rr_idx_t     idx_q, idx_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_ld_q, lft_ld_d, rght_ld_q, rght_ld_d;
    logic [11:0] steer_pot_q, steer_pot_d, batt_q, batt_d;
    logic        done;
    logic [15:0] rd_data;
    logic [2:0]  ch;
    logic        rd_hi_unused;

    spi_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_q),
        .cmd     (cmd_q),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    assign rd_hi_unused = ^rd_data[15:12];

    always_comb begin
        ch = idx_q == 2'd0 ? LFT_CH : idx_q == 2'd1 ? RGHT_CH : idx_q == 2'd2 ? STEER_CH : BATT_CH;
        state_d     = state_q;
        idx_d       = idx_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        lft_ld_d    = lft_ld_q;
        rght_ld_d   = rght_ld_q;
        steer_pot_d = steer_pot_q;
        batt_d      = batt_q;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    state_d = CNV;
                    wrt_d   = 1'b1;
                    cmd_d   = chan_cmd(ch);
                end
            end
            CNV: state_d = done ? GAP : CNV;
            GAP: begin
                state_d = READ;
                wrt_d   = 1'b1;
                cmd_d   = 16'h0000;
            end
            READ: begin
                if (done) begin
                    state_d     = IDLE;
                    idx_d       = idx_q + 2'd1;
                    lft_ld_d    = idx_q == 2'd0 ? rd_data[11:0] : lft_ld_q;
                    rght_ld_d   = idx_q == 2'd1 ? rd_data[11:0] : rght_ld_q;
                    steer_pot_d = idx_q == 2'd2 ? rd_data[11:0] : steer_pot_q;
                    batt_d      = idx_q == 2'd3 ? rd_data[11:0] : batt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            lft_ld_q    <= 12'h000;
            rght_ld_q   <= 12'h000;
            steer_pot_q <= 12'h000;
            batt_q      <= 12'h000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            lft_ld_q    <= lft_ld_d;
            rght_ld_q   <= rght_ld_d;
            steer_pot_q <= steer_pot_d;
            batt_q      <= batt_d;
        end
    end

    assign lft_ld    = lft_ld_q;
    assign rght_ld   = rght_ld_q;
    assign steer_pot = steer_pot_q;
    assign batt      = batt_q;

endmodule
